mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single unified RAM port between the IF stage (instruction fetch) and the MEM stage (load/store) of the 5-stage RV64I pipeline.
- Arbitrates between the two requesters and sequences each access through a request/grant/response FSM.
- Performs byte-lane alignment: write strobes and data shift on stores, shift and sign/zero extension on loads.
- Drives the IF and MEM stall outputs used by the hazard logic.

Parameters:
- ADDR_W, 64, width of request addresses (DATA_WIDTH).
- DATA_W, 64, RAM data width; fixed at 64, 8 byte lanes.
- STARVE_LIMIT, 4, consecutive MEM grants allowed while IF waits (only with ARB_STARVE_GUARD_EN).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address, 4-byte aligned
- if_kill  in  1  branch redirect; discard any fetch in flight
- if_rdata  out  32  fetched instruction
- if_valid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  if_req & ~if_valid
- mem_req  in  1  load/store request; held until mem_done
- mem_we  in  1  1 = store
- mem_addr  in  ADDR_W  byte address
- mem_wdata  in  64  store data, LSB-justified
- mem_size  in  3  funct3 (Detail field): 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- mem_rdata  out  64  aligned and extended load data
- mem_done  out  1  one-cycle completion pulse (loads and stores)
- mem_stall  out  1  mem_req & ~mem_done
- ram_req  out  1  RAM request; held until ram_gnt
- ram_we  out  1  RAM write
- ram_addr  out  ADDR_W  8-byte aligned (addr[2:0] = 0)
- ram_wdata  out  64  lane-shifted store data
- ram_wstrb  out  8  byte-lane enables
- ram_gnt  in  1  RAM accepted the request this cycle
- ram_rvalid  in  1  read data valid / write acknowledge
- ram_rdata  in  64  RAM read word

Behaviour:
- FSM states: IDLE, REQ_IF, WAIT_IF, REQ_MEM, WAIT_MEM.
- IDLE: requests sampled.
  - mem_req wins over if_req, since MEM holds the older instruction.
  - The winner's address, data, size and we are latched into registers. Next state is REQ_MEM or REQ_IF.
- REQ_x: ram_req=1 with the latched fields. On ram_gnt go to WAIT_x; otherwise stay with outputs stable.
- WAIT_x: ram_req=0. On ram_rvalid:
  - Pulse if_valid or mem_done combinationally in that same cycle.
  - Next state is IDLE; arbitration restarts the following cycle.
- Minimum latency: req seen at cycle t, REQ at t+1 with gnt, rvalid and done at t+2. One access in flight at a time.
- IF data: if_rdata = addr[2] ? ram_rdata[63:32] : ram_rdata[31:0].
- Store alignment:
  - ram_wstrb = size mask (B 0x01, H 0x03, W 0x0F, D 0xFF) << addr[2:0]; bits beyond lane 7 dropped.
  - ram_wdata = mem_wdata << (8*addr[2:0]).
  - Misaligned accesses are not detected.
- Loads: ram_wstrb = 0. mem_rdata = ram_rdata >> (8*addr[2:0]), then sign-extended (B/H/W) or zero-extended (BU/HU/WU) from the size width; D passes through unchanged.
- Kill:
  - if_kill in REQ_IF or WAIT_IF sets a kill flag.
  - ram_req stays asserted until gnt (RAM protocol requirement); the response is consumed but if_valid is suppressed.
  - The flag clears on exit from WAIT_IF.
  - if_kill in any other state: no effect.
  - if_kill coincident with ram_rvalid in WAIT_IF: suppressed.
- Stall outputs: if_stall and mem_stall are combinational.
  - A requester waiting while the other requester is served keeps its stall high.
  - IF remains stalled during the kill drain.
- Reset (asynchronous, any state): state=IDLE, latched registers=0, kill flag=0. ram_req, ram_we, ram_wstrb, if_valid and mem_done are 0.
  - A stale ram_rvalid after reset is ignored, because the FSM is not in a WAIT state.
- Outputs not listed above are 0 when not in the relevant state.

Optional Feature:
- Macro: ARB_STARVE_GUARD_EN.
- Defined:
  - A 3-bit counter increments on each MEM grant made while if_req=1, and clears on any IF grant.
  - When count == STARVE_LIMIT, IF wins the next IDLE arbitration.
- Undefined: strict MEM priority; no counter logic.

Decomposition:
- pipeline_pkg gains:
  - arb_state_t enum.
  - MEM_SZ_B/H/W/D/BU/HU/WU localparams.
  - mem_req_t packed struct {addr, wdata, size, we}, used for the latch register.
- One combinational sub-module, mem_lane_align: size/offset in; wstrb, shifted wdata and extended rdata out. It is shared by the store and load paths and unit-tested alone.

Test Plan:
- IF only, if_addr=0x1004, gnt same cycle, rvalid next cycle, ram_rdata=0xDEADBEEF_00000013 -> if_rdata=0xDEADBEEF; if_valid pulses exactly at t+2; if_stall high t..t+1.
- if_req and mem_req together (load D at 0x2000) -> MEM served first. IF is served starting the cycle after mem_done; if_stall stays high throughout.
- Store H, mem_addr=0x3006, wdata=0xABCD -> ram_wstrb=0xC0, ram_wdata=0xABCD_0000_0000_0000, ram_addr=0x3000, ram_we=1.
- Load B at 0x4003, ram_rdata=0x0000_0000_8000_0000 -> mem_rdata=0xFFFF_FFFF_FFFF_FF80. Same access as BU -> 0x80.
- ram_gnt withheld 5 cycles -> ram_req and ram_addr stable. Assert if_kill during the wait -> the later rvalid produces no if_valid; FSM returns to IDLE.
- rst_n low while in WAIT_MEM, then rvalid arrives -> no mem_done, state IDLE, ram_req=0. With ARB_STARVE_GUARD_EN: 4 consecutive MEM grants with IF pending -> IF wins the 5th arbitration.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM state, load/store size codes and request latch type
package mem_port_arbiter_pkg;
   typedef enum logic [2:0] {IDLE, REQ_IF, WAIT_IF, REQ_MEM, WAIT_MEM} arb_state_t;
   localparam logic [2:0] MEM_SZ_B  = 3'b000;
   localparam logic [2:0] MEM_SZ_H  = 3'b001;
   localparam logic [2:0] MEM_SZ_W  = 3'b010;
   localparam logic [2:0] MEM_SZ_D  = 3'b011;
   localparam logic [2:0] MEM_SZ_BU = 3'b100;
   localparam logic [2:0] MEM_SZ_HU = 3'b101;
   localparam logic [2:0] MEM_SZ_WU = 3'b110;
   typedef struct packed {
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [2:0]  size;
      logic        we;
   } mem_req_t;
endpackage

// File: rtl/mem_port_arbiter_lane_align.sv
// mem_lane_align: byte-lane alignment for a 64-bit RAM word
// Ports: size_i (funct3), offset_i (addr[2:0]), wdata_i/rdata_i in;
//        wstrb_o, wdata_o (lane-shifted store data), rdata_o (shifted, extended load data) out.
module mem_lane_align
   import mem_port_arbiter_pkg::*;
(
   input  logic [2:0]  size_i,
   input  logic [2:0]  offset_i,
   input  logic [63:0] wdata_i,
   input  logic [63:0] rdata_i,
   output logic [7:0]  wstrb_o,
   output logic [63:0] wdata_o,
   output logic [63:0] rdata_o
);
   logic [7:0]  mask;
   logic [63:0] sh;
   assign mask = (size_i[1:0] == 2'd0) ? 8'h01 :
                 (size_i[1:0] == 2'd1) ? 8'h03 :
                 (size_i[1:0] == 2'd2) ? 8'h0F : 8'hFF;
   // Lanes shifted past byte 7 fall off the 8-bit result.
   assign wstrb_o = mask << offset_i;
   assign wdata_o = wdata_i << {offset_i, 3'b000};
   assign sh      = rdata_i >> {offset_i, 3'b000};
   assign rdata_o = (size_i == MEM_SZ_B)  ? {{56{sh[7]}}, sh[7:0]}   :
                    (size_i == MEM_SZ_H)  ? {{48{sh[15]}}, sh[15:0]} :
                    (size_i == MEM_SZ_W)  ? {{32{sh[31]}}, sh[31:0]} :
                    (size_i == MEM_SZ_BU) ? {56'd0, sh[7:0]}         :
                    (size_i == MEM_SZ_HU) ? {48'd0, sh[15:0]}        :
                    (size_i == MEM_SZ_WU) ? {32'd0, sh[31:0]}        : sh;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch and load/store
// Ports: if_* fetch requester (req/addr/kill in; rdata/valid/stall out),
//        mem_* load/store requester (req/we/addr/wdata/size in; rdata/done/stall out),
//        ram_* RAM port (req/we/addr/wdata/wstrb out; gnt/rvalid/rdata in).
// Optional: define ARB_STARVE_GUARD_EN to let IF win after STARVE_LIMIT MEM grants while it waits.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_kill,
   output logic [31:0]       if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   input  logic [2:0]        mem_size,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              mem_done,
   output logic              mem_stall,
   output logic              ram_req,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic [7:0]        ram_wstrb,
   input  logic              ram_gnt,
   input  logic              ram_rvalid,
   input  logic [DATA_W-1:0] ram_rdata
);
   if (DATA_W != 64 || ADDR_W < 8 || ADDR_W > 64 || STARVE_LIMIT < 1 || STARVE_LIMIT > 7) begin : g_bad_cfg
      $error("mem_port_arbiter: unsupported parameter set");
   end
   arb_state_t  state_q, state_d;
   mem_req_t    req_q, req_d;
   logic        kill_q, kill_d;
   logic        starve_hit, grant_if, grant_mem, wr_act;
   logic [7:0]  al_wstrb;
   logic [63:0] al_wdata, al_rdata;
   assign grant_if  = (state_q == IDLE) & if_req & (~mem_req | starve_hit);
   assign grant_mem = (state_q == IDLE) & mem_req & ~grant_if;
`ifdef ARB_STARVE_GUARD_EN
   logic [2:0] starve_q, starve_d;
   assign starve_hit = starve_q == 3'(STARVE_LIMIT);
   assign starve_d   = grant_if ? 3'd0 : (grant_mem & if_req) ? starve_q + 3'd1 : starve_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) starve_q <= 3'd0;
      else starve_q <= starve_d;
   end
`else
   assign starve_hit = 1'b0;
`endif
   mem_lane_align u_align (
      .size_i   (req_q.size),
      .offset_i (req_q.addr[2:0]),
      .wdata_i  (req_q.wdata),
      .rdata_i  (ram_rdata),
      .wstrb_o  (al_wstrb),
      .wdata_o  (al_wdata),
      .rdata_o  (al_rdata)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         req_q   <= '0;
         kill_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         kill_q  <= kill_d;
      end
   end
   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      kill_d   = kill_q;
      ram_req  = 1'b0;
      if_valid = 1'b0;
      mem_done = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_mem) begin
               req_d   = '{addr: 64'(mem_addr), wdata: mem_wdata, size: mem_size, we: mem_we};
               state_d = REQ_MEM;
            end else if (grant_if) begin
               req_d   = '{addr: 64'(if_addr), wdata: 64'd0, size: MEM_SZ_W, we: 1'b0};
               state_d = REQ_IF;
            end
         end
         REQ_IF: begin
            ram_req = 1'b1;
            kill_d  = kill_q | if_kill;
            state_d = ram_gnt ? WAIT_IF : REQ_IF;
         end
         WAIT_IF: begin
            kill_d = kill_q | if_kill;
            if (ram_rvalid) begin
               // A killed fetch still consumes its response, silently.
               if_valid = ~(kill_q | if_kill);
               kill_d   = 1'b0;
               state_d  = IDLE;
            end
         end
         REQ_MEM: begin
            ram_req = 1'b1;
            state_d = ram_gnt ? WAIT_MEM : REQ_MEM;
         end
         WAIT_MEM: begin
            mem_done = ram_rvalid;
            state_d  = ram_rvalid ? IDLE : WAIT_MEM;
         end
         default: state_d = IDLE;
      endcase
   end
   assign wr_act    = ram_req & req_q.we;
   assign ram_we    = wr_act;
   assign ram_wstrb = wr_act ? al_wstrb : 8'd0;
   assign ram_wdata = wr_act ? al_wdata : '0;
   assign ram_addr  = ram_req ? ADDR_W'({req_q.addr[63:3], 3'b000}) : '0;
   assign if_rdata  = if_valid ? (req_q.addr[2] ? ram_rdata[63:32] : ram_rdata[31:0]) : 32'd0;
   assign mem_rdata = mem_done ? al_rdata : '0;
   assign if_stall  = if_req & ~if_valid;
   assign mem_stall = mem_req & ~mem_done;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench with a transaction-level RAM and lane model
module tb_mem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_kill, if_valid, if_stall;
   logic [63:0] if_addr;
   logic [31:0] if_rdata;
   logic        mem_req, mem_we, mem_done, mem_stall;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [2:0]  mem_size;
   logic        ram_req, ram_we, ram_gnt, ram_rvalid;
   logic [63:0] ram_addr, ram_wdata, ram_rdata;
   logic [7:0]  ram_wstrb;
   int          n_chk = 0;
   int          n_pass = 0;
   bit          ram_auto;
   bit          rv_pending;
   int          gnt_delay, rv_delay, gcnt, rvcnt;
   logic [63:0] ram_word;

   mem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_kill(if_kill),
      .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_size(mem_size), .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
      .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_wstrb(ram_wstrb), .ram_gnt(ram_gnt), .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] exp_strb(input logic [2:0] sz, input logic [2:0] off);
      int n = 1 << sz[1:0];
      logic [7:0] s = '0;
      for (int i = 0; i < 8; i++) if (i >= int'(off) && i < int'(off) + n) s[i] = 1'b1;
      return s;
   endfunction

   function automatic logic [63:0] exp_wdata(input logic [63:0] wd, input logic [2:0] off);
      logic [63:0] r = '0;
      for (int i = 0; i < 8; i++) if (i >= int'(off)) r[8*i +: 8] = wd[8*(i-int'(off)) +: 8];
      return r;
   endfunction

   function automatic logic [63:0] exp_load(input logic [63:0] word, input logic [2:0] sz, input logic [2:0] off);
      logic [63:0] v = word >> (8 * int'(off));
      logic [63:0] m;
      int bits = 8 * (1 << sz[1:0]);
      if (bits < 64) begin
         m = (64'd1 << bits) - 64'd1;
         v = v & m;
         if (!sz[2] && v[bits-1]) v = v | ~m;
      end
      return v;
   endfunction

   task automatic ram_model();
      if (!ram_auto) return;
      ram_gnt    = 1'b0;
      ram_rvalid = 1'b0;
      ram_rdata  = ram_word;
      if (rv_pending) begin
         if (rvcnt == 0) begin
            ram_rvalid = 1'b1;
            rv_pending = 1'b0;
         end else rvcnt--;
      end else if (ram_req) begin
         if (gcnt >= gnt_delay) begin
            ram_gnt    = 1'b1;
            rv_pending = 1'b1;
            rvcnt      = rv_delay;
            gcnt       = 0;
         end else gcnt++;
      end
   endtask

   task automatic step();
      @(negedge clk);
      ram_model();
      #1;
   endtask

   task automatic run_op(input bit want_if, input bit want_mem, input logic [63:0] ia, input logic [63:0] ma,
                         input logic [63:0] wd, input logic [2:0] sz, input bit we, input logic [63:0] word,
                         input int gd, input int rd);
      bit mem_pend = want_mem;
      bit if_pend = want_if;
      bit mem_gnt_seen = 1'b0;
      int cyc = 0;
      int done_cyc = -1;
      gnt_delay = gd;
      rv_delay  = rd;
      ram_word  = word;
      if_req    = want_if;
      if_addr   = ia;
      mem_req   = want_mem;
      mem_addr  = ma;
      mem_wdata = wd;
      mem_size  = sz;
      mem_we    = we;
      #1;
      while ((mem_pend || if_pend) && cyc < 100) begin
         chk("if_stall", if_stall, if_req & ~if_valid);
         chk("mem_stall", mem_stall, mem_req & ~mem_done);
         if (ram_req && ram_gnt) begin
            if (mem_pend && !mem_gnt_seen) begin
               mem_gnt_seen = 1'b1;
               chk("mem_ram_addr", ram_addr, {ma[63:3], 3'b000});
               chk("mem_ram_we", ram_we, we);
               chk("mem_ram_wstrb", ram_wstrb, we ? exp_strb(sz, ma[2:0]) : 8'h00);
               if (we) chk("mem_ram_wdata", ram_wdata, exp_wdata(wd, ma[2:0]));
            end else begin
               chk("if_ram_addr", ram_addr, {ia[63:3], 3'b000});
               chk("if_ram_we", ram_we, 1'b0);
               chk("if_ram_wstrb", ram_wstrb, 8'h00);
               if (want_mem && gd == 0) chk("if_after_mem", cyc, done_cyc + 2);
            end
         end
         if (mem_done) begin
            chk("mem_done_once", mem_pend, 1'b1);
            if (!we) chk("mem_rdata", mem_rdata, exp_load(word, sz, ma[2:0]));
            if (!want_if && gd == 0 && rd == 0) chk("mem_latency", cyc, 2);
            mem_pend = 1'b0;
            done_cyc = cyc;
            mem_req  = 1'b0;
         end
         if (if_valid) begin
            chk("if_valid_once", if_pend, 1'b1);
            chk("if_rdata", if_rdata, ia[2] ? word[63:32] : word[31:0]);
            if (want_mem) chk("if_after_mem_done", mem_pend, 1'b0);
            if (!want_mem && gd == 0 && rd == 0) chk("if_latency", cyc, 2);
            if_pend = 1'b0;
            if_req  = 1'b0;
         end
         step();
         cyc++;
      end
      chk("op_complete", mem_pend | if_pend, 1'b0);
   endtask

   initial begin
      ram_auto   = 1'b0;
      rv_pending = 1'b0;
      gcnt = 0; rvcnt = 0; gnt_delay = 0; rv_delay = 0;
      ram_word = '0;
      rst_n = 1'b0;
      if_req = 0; if_kill = 0; if_addr = '0;
      mem_req = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_size = '0;
      ram_gnt = 0; ram_rvalid = 0; ram_rdata = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ram_req", ram_req, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ram_wstrb", ram_wstrb, 8'h00);
      chk("rst_if_valid", if_valid, 1'b0);
      chk("rst_mem_done", mem_done, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      ram_rvalid = 1'b1;
      #1;
      chk("stale_rv_if", if_valid, 1'b0);
      chk("stale_rv_mem", mem_done, 1'b0);
      @(negedge clk);
      ram_rvalid = 1'b0;
      ram_auto = 1'b1;
      #1;

      run_op(1, 0, 64'h1004, 0, 0, 3'b000, 0, 64'hDEADBEEF_00000013, 0, 0);
      run_op(1, 1, 64'h1008, 64'h2000, 0, 3'b011, 0, 64'h0123_4567_89AB_CDEF, 0, 0);
      run_op(0, 1, 0, 64'h3006, 64'hABCD, 3'b001, 1, 64'h0, 0, 0);
      run_op(0, 1, 0, 64'h4003, 0, 3'b000, 0, 64'h0000_0000_8000_0000, 0, 0);
      run_op(0, 1, 0, 64'h4003, 0, 3'b100, 0, 64'h0000_0000_8000_0000, 0, 0);

      begin : kill_test
         logic [63:0] last_a = '0;
         int gnts = 0;
         bit got = 1'b0;
         gnt_delay = 5;
         rv_delay  = 1;
         ram_word  = 64'h1111_2222_3333_4444;
         if_req  = 1'b1;
         if_addr = 64'h5000;
         #1;
         for (int c = 0; c < 60 && !got; c++) begin
            chk("kill_if_stall", if_stall, if_req & ~if_valid);
            if (gnts == 0 && c >= 1) begin
               chk("hold_ram_req", ram_req, 1'b1);
               chk("hold_ram_addr", ram_addr, 64'h5000);
            end
            if (ram_req && ram_gnt) begin
               gnts++;
               last_a = ram_addr;
            end
            if (if_valid) begin
               got = 1'b1;
               chk("kill_gnt_count", gnts, 2);
               chk("kill_refetch_addr", last_a, 64'h6000);
               chk("kill_refetch_data", if_rdata, 64'h3333_4444);
            end
            if (c == 3) begin
               if_kill = 1'b1;
               if_addr = 64'h6000;
            end
            if (c == 4) if_kill = 1'b0;
            if (!got) step();
         end
         chk("kill_refetch_done", got, 1'b1);
         if_req = 1'b0;
         step();
         chk("kill_back_idle", ram_req, 1'b0);
      end

      begin : reset_test
         ram_auto = 1'b0;
         rv_pending = 1'b0;
         gcnt = 0;
         ram_rdata = 64'hFFFF_0000_FFFF_0000;
         mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h7000; mem_size = 3'b011;
         @(negedge clk);
         ram_gnt = 1'b1;
         #1;
         chk("rst_test_req", ram_req, 1'b1);
         @(negedge clk);
         ram_gnt = 1'b0;
         rst_n = 1'b0;
         #1;
         chk("rst_async_req", ram_req, 1'b0);
         chk("rst_async_done", mem_done, 1'b0);
         mem_req = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         ram_rvalid = 1'b1;
         #1;
         chk("rst_late_rv_done", mem_done, 1'b0);
         chk("rst_late_rv_req", ram_req, 1'b0);
         @(negedge clk);
         ram_rvalid = 1'b0;
         #1;
         chk("rst_idle_req", ram_req, 1'b0);
         ram_auto = 1'b1;
      end

      for (int k = 0; k < 40; k++) begin
         bit wm = ($urandom % 4) != 0;
         bit wi = wm ? bit'($urandom % 2) : 1'b1;
         run_op(wi, wm, {$urandom, $urandom_range(0, 1), 2'b00}, {$urandom, $urandom},
                {$urandom, $urandom}, 3'($urandom_range(0, 6)), bit'($urandom % 2),
                {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3));
      end

`ifdef ARB_STARVE_GUARD_EN
      begin : starve_test
         int md = 0;
         bit got = 1'b0;
         gnt_delay = 0; rv_delay = 0;
         ram_word = 64'h0BAD_F00D_1234_5678;
         if_req = 1'b1; if_addr = 64'h9000;
         mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h8000; mem_size = 3'b011;
         #1;
         for (int c = 0; c < 80 && !got; c++) begin
            if (mem_done) md++;
            if (if_valid) begin
               got = 1'b1;
               chk("starve_mem_grants", md, 4);
            end
            if (!got) step();
         end
         chk("starve_if_served", got, 1'b1);
         if_req = 1'b0;
         mem_req = 1'b0;
         step();
         step();
      end
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
